// File: rtl/cfs_pkg.sv
// Shared definitions for the colour frame sequencer.
//   - Filter encodings driven on S2/S3.
//   - FSM state encoding.
//   - Channel index to filter mapping (measurement order RED, BLUE, GREEN, CLEAR).
package cfs_pkg;

    localparam logic [1:0] FLT_RED   = 2'b00;
    localparam logic [1:0] FLT_BLUE  = 2'b01;
    localparam logic [1:0] FLT_GREEN = 2'b11;
    localparam logic [1:0] FLT_CLEAR = 2'b10;

    // Channel index of the last channel in a frame
    localparam logic [1:0] CH_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSettle  = 2'd1,
        StMeasure = 2'd2,
        StPresent = 2'd3
    } cfs_state_e;

    function automatic logic [1:0] ch_to_filter(input logic [1:0] ch);
        logic [1:0] flt;
        case (ch)
            2'd0:    flt = FLT_RED;
            2'd1:    flt = FLT_BLUE;
            2'd2:    flt = FLT_GREEN;
            default: flt = FLT_CLEAR;
        endcase
        return flt;
    endfunction

endpackage

// File: rtl/cfs_edge_counter.sv
// Synchroniser, rising-edge detector and gated saturating edge counter.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sensor_freq  raw asynchronous sensor output
//   en           count detected edges this cycle
//   clr          clear the stored count at the end of this cycle
//   count        running count including an edge detected this cycle
//   sat          count is at its saturation value
module cfs_edge_counter #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_freq,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sensor_freq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= clr ? '0 : count;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // Combinational so a window-closing latch sees an edge detected in its last cycle
    always_comb begin
        count = cnt_q;
        if (en && rise && (cnt_q != CNT_MAX)) begin
            count = cnt_q + 1'b1;
        end
    end

    assign sat = (count == CNT_MAX);

endmodule

// File: rtl/color_frame_sequencer.sv
// Steps a TCS3200-style sensor through RED, BLUE, GREEN, CLEAR, counts sensor edges over a
// fixed gate window per channel and presents the four counts as one valid/ready frame.
// Optional feature: define CFS_SETTLE_EN to insert SETTLE_CYCLES dead cycles before each window.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               measure frames back-to-back; 0 = finish current frame then idle
//   sensor_freq       raw sensor output (asynchronous)
//   scale, filter     sensor S0/S1 and S2/S3
//   busy              not idle
//   frame_valid       frame presented, held until frame_ready
//   frame_ready       consumer accepts frame
//   red_cnt..clear_cnt, sat  presented frame counts and saturation flag
module color_frame_sequencer
    import cfs_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned CNT_W         = 20,
    parameter logic [1:0]  SCALE_SEL     = 2'b11,
    parameter int unsigned SETTLE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sensor_freq,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic             busy,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             sat
);

    localparam int unsigned TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);

`ifdef CFS_SETTLE_EN
    localparam cfs_state_e    StWindow    = StSettle;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
`else
    localparam cfs_state_e    StWindow    = StMeasure;
`endif

    cfs_state_e       state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [1:0]       ch_q, ch_d;
    logic [CNT_W-1:0] red_sh_q, blue_sh_q, green_sh_q;
    logic [2:0]       sat_sh_q;
    logic [CNT_W-1:0] red_q, blue_q, green_q, clear_q;
    logic             sat_q, frame_valid_q;

    logic             cnt_en, cnt_clr, latch;
    logic [CNT_W-1:0] count;
    logic             cnt_sat;

    cfs_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk         (clk),
        .rst         (rst),
        .sensor_freq (sensor_freq),
        .en          (cnt_en),
        .clr         (cnt_clr),
        .count       (count),
        .sat         (cnt_sat)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        ch_d    = ch_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    ch_d    = 2'd0;
                    tmr_d   = '0;
                    state_d = StWindow;
                end
            end
`ifdef CFS_SETTLE_EN
            StSettle: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = StMeasure;
                end
            end
`endif
            StMeasure: begin
                cnt_en  = 1'b1;
                cnt_clr = 1'b0;
                tmr_d   = tmr_q + 1'b1;
                if (tmr_q == GATE_LAST) begin
                    cnt_clr = 1'b1;
                    latch   = 1'b1;
                    tmr_d   = '0;
                    if (ch_q == CH_CLEAR) begin
                        ch_d    = 2'd0;
                        state_d = StPresent;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = StWindow;
                    end
                end
            end
            StPresent: begin
                if (frame_ready) begin
                    state_d = run ? StWindow : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            tmr_q         <= '0;
            ch_q          <= 2'd0;
            red_sh_q      <= '0;
            blue_sh_q     <= '0;
            green_sh_q    <= '0;
            sat_sh_q      <= '0;
            red_q         <= '0;
            blue_q        <= '0;
            green_q       <= '0;
            clear_q       <= '0;
            sat_q         <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ch_q    <= ch_d;
            if (latch) begin
                case (ch_q)
                    2'd0: begin
                        red_sh_q    <= count;
                        sat_sh_q[0] <= cnt_sat;
                    end
                    2'd1: begin
                        blue_sh_q   <= count;
                        sat_sh_q[1] <= cnt_sat;
                    end
                    2'd2: begin
                        green_sh_q  <= count;
                        sat_sh_q[2] <= cnt_sat;
                    end
                    default: begin
                        // CLEAR closes the frame: its count goes straight to the output so the
                        // whole frame is visible on the first PRESENT cycle.
                        red_q         <= red_sh_q;
                        blue_q        <= blue_sh_q;
                        green_q       <= green_sh_q;
                        clear_q       <= count;
                        sat_q         <= (|sat_sh_q) | cnt_sat;
                        frame_valid_q <= 1'b1;
                    end
                endcase
            end else if ((state_q == StPresent) && frame_ready) begin
                frame_valid_q <= 1'b0;
            end
        end
    end

    assign scale       = SCALE_SEL;
    assign filter      = ch_to_filter(ch_q);
    assign busy        = (state_q != StIdle);
    assign frame_valid = frame_valid_q;
    assign red_cnt     = red_q;
    assign blue_cnt    = blue_q;
    assign green_cnt   = green_q;
    assign clear_cnt   = clear_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_color_frame_sequencer.sv
module tb_color_frame_sequencer;

    localparam int G      = 100;
    localparam int CW     = 8;
    localparam int S_CFG  = 20;
`ifdef CFS_SETTLE_EN
    localparam int S      = S_CFG;
`else
    localparam int S      = 0;
`endif
    localparam int T      = S + G;
    localparam int G2     = 200;
    localparam int CW2    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic sensor = 1'b0;
    logic ready = 1'b0;
    logic [1:0] scale, filter;
    logic busy, fv, sat;
    logic [CW-1:0] red, blue, green, clr_c;

    logic run2 = 1'b0;
    logic sensor2 = 1'b0;
    logic [1:0] scale2, filter2;
    logic busy2, fv2, sat2;
    logic [CW2-1:0] red2, blue2, green2, clr2;

    color_frame_sequencer #(
        .GATE_CYCLES (G), .CNT_W (CW), .SCALE_SEL (2'b11), .SETTLE_CYCLES (S_CFG)
    ) u_dut (
        .clk (clk), .rst (rst), .run (run), .sensor_freq (sensor),
        .scale (scale), .filter (filter), .busy (busy), .frame_valid (fv),
        .frame_ready (ready), .red_cnt (red), .blue_cnt (blue), .green_cnt (green),
        .clear_cnt (clr_c), .sat (sat)
    );

    // Narrow counter with a longer window so a fast sensor can overrun it
    color_frame_sequencer #(
        .GATE_CYCLES (G2), .CNT_W (CW2), .SCALE_SEL (2'b11), .SETTLE_CYCLES (S_CFG)
    ) u_sat (
        .clk (clk), .rst (rst), .run (run2), .sensor_freq (sensor2),
        .scale (scale2), .filter (filter2), .busy (busy2), .frame_valid (fv2),
        .frame_ready (1'b1), .red_cnt (red2), .blue_cnt (blue2), .green_cnt (green2),
        .clear_cnt (clr2), .sat (sat2)
    );

    always #5 clk = ~clk;

    // Edge index and the sensor level sampled at each edge
    int cyc = 0;
    bit hist [0:32767];
    always @(posedge clk) begin
        hist[cyc] = sensor;
        cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;
    int mode = 0;  // 0 quiet, 1 period by filter, 2 random

    function automatic int period_of(input logic [1:0] f);
        case (f)
            2'b00:   return 4;
            2'b01:   return 5;
            2'b11:   return 10;
            default: return 2;
        endcase
    endfunction

    initial begin
        int ph;
        int p;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) begin
                p = period_of(filter);
                ph = (ph + 1) % p;
                sensor = (ph < p / 2);
            end else if (mode == 2) begin
                sensor = 1'($urandom_range(0, 1));
            end else begin
                sensor = 1'b0;
            end
            sensor2 = ~sensor2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: edges of the synchronised sensor (2-cycle delayed) inside channel c's window,
    // where r is the edge at which the frame was started.
    function automatic int model_cnt(input int r, input int c, input int cw);
        int n;
        int st;
        int mx;
        n = 0;
        st = r + 1 + c * T + S;
        for (int e = st; e < st + G; e++) begin
            if (hist[e-2] && !hist[e-3]) n++;
        end
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic goto(input int e);
        while (cyc <= e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output int v);
        v = -1;
        for (int i = 0; i < 4 * T + 50; i++) begin
            @(posedge clk);
            #1;
            if (fv) begin
                v = cyc - 1;
                break;
            end
        end
        chk("valid_timeout", 32'(v != -1), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int r, input int v);
        int e [4];
        bit es;
        es = 1'b0;
        for (int c = 0; c < 4; c++) begin
            e[c] = model_cnt(r, c, CW);
            if (e[c] == (1 << CW) - 1) es = 1'b1;
        end
        chk({tag, "_latency"}, 32'(v - r), 32'(4 * T));
        chk({tag, "_red"},   32'(red),   32'(e[0]));
        chk({tag, "_blue"},  32'(blue),  32'(e[1]));
        chk({tag, "_green"}, 32'(green), 32'(e[2]));
        chk({tag, "_clear"}, 32'(clr_c), 32'(e[3]));
        chk({tag, "_sat"},   32'(sat),   32'(es));
    endtask

    initial begin
        int r, v, r2, v2, r3, v3, r4, x, r5, v5, r6, v6, bad;
        logic [1:0] flt_tab [4];
        logic [CW-1:0] h_red, h_blue, h_green, h_clr;
        flt_tab[0] = 2'b00;
        flt_tab[1] = 2'b01;
        flt_tab[2] = 2'b11;
        flt_tab[3] = 2'b10;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_scale", 32'(scale), 32'd3);
        chk("rst_filter", 32'(filter), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(fv), 32'd0);
        chk("rst_counts", 32'({red, blue, green, clr_c}), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);

        // Test 1: per-filter periods, back-to-back frames
        rst = 1'b0;
        ready = 1'b1;
        mode = 1;
        run = 1'b1;
        run2 = 1'b1;
        r = cyc;
        goto(r + 2);
        run2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            goto(r + c * T + S + G / 2);
            chk("t1_filter", 32'(filter), 32'(flt_tab[c]));
            chk("t1_busy", 32'(busy), 32'd1);
        end
        wait_valid(v);
        check_frame("t1", r, v);
        chk("t1_red_nom", 32'(red >= 24 && red <= 26), 32'd1);
        chk("t1_blue_nom", 32'(blue >= 19 && blue <= 21), 32'd1);
        chk("t1_green_nom", 32'(green >= 9 && green <= 11), 32'd1);
        chk("t1_clear_nom", 32'(clr_c >= 49 && clr_c <= 51), 32'd1);
        chk("t1_filter_present", 32'(filter), 32'd0);
        r2 = v + 1;
        goto(r2);
        chk("t1_valid_drop", 32'(fv), 32'd0);
        ready = 1'b0;
        mode = 2;

        // Test 3: narrow counter saturates
        goto(r + 4 * (S + G2) - 1);
        chk("t3_valid_early", 32'(fv2), 32'd0);
        goto(r + 4 * (S + G2));
        chk("t3_valid", 32'(fv2), 32'd1);
        chk("t3_red", 32'(red2), 32'((G2 / 2 > 63) ? 63 : G2 / 2));
        chk("t3_clear", 32'(clr2), 32'((G2 / 2 > 63) ? 63 : G2 / 2));
        chk("t3_sat", 32'(sat2), 32'd1);

        // Test 2: consumer stalls for 500 cycles
        wait_valid(v2);
        check_frame("t2", r2, v2);
        h_red = red;
        h_blue = blue;
        h_green = green;
        h_clr = clr_c;
        bad = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (!fv || filter != 2'b00 || red != h_red || blue != h_blue ||
                green != h_green || clr_c != h_clr) bad++;
        end
        chk("t2_hold", 32'(bad), 32'd0);
        ready = 1'b1;
        r3 = cyc;
        goto(r3);
        chk("t2_valid_drop", 32'(fv), 32'd0);
        wait_valid(v3);
        check_frame("t2_next", r3, v3);

        // Test 4: reset in the BLUE window
        r4 = v3 + 1;
        goto(r4 + T + S + G / 2 - 6);
        chk("t4_blue", 32'(filter), 32'd1);
        mode = 0;
        goto(r4 + T + S + G / 2);
        rst = 1'b1;
        x = cyc;
        goto(x);
        chk("t4_filter", 32'(filter), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valid", 32'(fv), 32'd0);
        chk("t4_counts", 32'({red, blue, green, clr_c}), 32'd0);
        chk("t4_sat", 32'(sat), 32'd0);
        chk("t4_scale", 32'(scale), 32'd3);
        rst = 1'b0;
        mode = 2;
        r5 = cyc;
        goto(r5 + S + 5);
        chk("t4_restart_red", 32'(filter), 32'd0);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_valid(v5);
        check_frame("t4", r5, v5);

        // Test 5: run dropped mid-GREEN
        r6 = v5 + 1;
        goto(r6 + 2 * T + S + G / 2);
        chk("t5_green", 32'(filter), 32'd3);
        run = 1'b0;
        wait_valid(v6);
        check_frame("t5", r6, v6);
        goto(v6 + 1);
        chk("t5_valid_drop", 32'(fv), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        goto(v6 + 60);
        chk("t5_stay_idle", 32'(busy), 32'd0);
        chk("t5_filter", 32'(filter), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
